// File: rtl/iomem_master_if.sv
// Bundles the command, response and iomem bus signals of the iomem initiator.
// master: the initiator's view. slave: the view of whatever drives commands,
// consumes responses and answers the bus.
interface iomem_master_if;
    // Command port
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;

    // Response port
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    // iomem bus
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  rsp_ready,
        input  iomem_ready, iomem_rdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output rsp_ready,
        output iomem_ready, iomem_rdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
    );
endinterface

// File: rtl/iomem_master.sv
// iomem bus initiator: turns single read/write commands into one PicoSoC
// iomem transaction each and returns the result on a response port.
// A watchdog ends a bus request that no responder answers.
module iomem_master #(
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          TO_W           = 16,
    parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
    input  logic           clk,
    input  logic           resetn,
    iomem_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // The counter holds the number of BUS cycles already completed, so the
    // request expires in the BUS cycle where it equals TIMEOUT_CYCLES-1;
    // that keeps iomem_valid high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] CNT_ONE = 1;
    localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);

    state_t            state_reg, state_next;
    logic              iomem_valid_reg, iomem_valid_next;
    logic [31:0]       iomem_addr_reg, iomem_addr_next;
    logic [31:0]       iomem_wdata_reg, iomem_wdata_next;
    logic [3:0]        iomem_wstrb_reg, iomem_wstrb_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [31:0]       rsp_rdata_reg, rsp_rdata_next;
    logic              rsp_error_reg, rsp_error_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;

    // State and all registered outputs; reset discards any transaction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            iomem_valid_reg <= 1'b0;
            iomem_addr_reg  <= '0;
            iomem_wdata_reg <= '0;
            iomem_wstrb_reg <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_error_reg   <= 1'b0;
            to_cnt_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            iomem_valid_reg <= iomem_valid_next;
            iomem_addr_reg  <= iomem_addr_next;
            iomem_wdata_reg <= iomem_wdata_next;
            iomem_wstrb_reg <= iomem_wstrb_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_error_reg   <= rsp_error_next;
            to_cnt_reg      <= to_cnt_next;
        end
    end

    // Next-state and next-output decode: everything holds unless the current state acts.
    always_comb begin
        state_next       = state_reg;
        iomem_valid_next = iomem_valid_reg;
        iomem_addr_next  = iomem_addr_reg;
        iomem_wdata_next = iomem_wdata_reg;
        iomem_wstrb_next = iomem_wstrb_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_error_next   = rsp_error_reg;
        to_cnt_next      = to_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_write && (bus.cmd_wstrb == 4'b0000)) begin
                        // A write with no byte enabled is rejected without touching the bus.
                        state_next     = RSP;
                        rsp_valid_next = 1'b1;
                        rsp_error_next = 1'b1;
                        rsp_rdata_next = ERR_RDATA;
                    end else begin
                        state_next       = BUS;
                        iomem_valid_next = 1'b1;
                        iomem_addr_next  = bus.cmd_addr;
                        iomem_wdata_next = bus.cmd_wdata;
                        iomem_wstrb_next = bus.cmd_write ? bus.cmd_wstrb : 4'b0000;
                    end
                end
            end

            BUS: begin
                if (bus.iomem_ready) begin
                    // Ready has priority over a watchdog expiry in the same cycle.
                    state_next       = RSP;
                    iomem_valid_next = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_error_next   = 1'b0;
                    rsp_rdata_next   = (iomem_wstrb_reg == 4'b0000) ? bus.iomem_rdata : 32'h0;
                    to_cnt_next      = '0;
                end else if (TO_EN && (to_cnt_reg == TO_LAST)) begin
                    state_next       = RSP;
                    iomem_valid_next = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_error_next   = 1'b1;
                    rsp_rdata_next   = ERR_RDATA;
                    to_cnt_next      = '0;
                end else begin
                    to_cnt_next = to_cnt_reg + CNT_ONE;
                end
            end

            RSP: begin
                // iomem_ready is ignored here; only the response handshake moves on.
                if (bus.rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready   = (state_reg == IDLE);
    assign bus.iomem_valid = iomem_valid_reg;
    assign bus.iomem_addr  = iomem_addr_reg;
    assign bus.iomem_wdata = iomem_wdata_reg;
    assign bus.iomem_wstrb = iomem_wstrb_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_rdata   = rsp_rdata_reg;
    assign bus.rsp_error   = rsp_error_reg;

endmodule

// File: tb/tb_iomem_master.sv
// Bench for iomem_master: directed scenarios plus randomized transactions.
// Each transaction's outcome (bus length, response data/error) is predicted
// from the command and the responder behaviour; a negedge monitor checks the
// DUT against that prediction every cycle.
module tb_iomem_master;
    localparam int T = 8;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    iomem_master_if bus_if ();

    iomem_master #(
        .TIMEOUT_CYCLES(T),
        .TO_W(16),
        .ERR_RDATA(ERR)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus_if.master)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Expected outcome of the transaction in progress
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_wstrb;
    logic        exp_err, exp_illegal;
    int          exp_len;

    // Monitor state
    bit          mon_en = 1'b0;
    int          valid_run = 0;
    int          last_len = 0;
    int          rsp_seen = 0;
    logic        prev_valid = 1'b0, prev_rsp = 1'b0, prev_err = 1'b0, last_err = 1'b0;
    logic [31:0] prev_rdata = '0, last_rdata = '0;

    // Per-cycle compare against the predicted transaction
    always @(negedge clk) begin
        if (!mon_en || !resetn) begin
            valid_run  = 0;
            prev_valid = 1'b0;
            prev_rsp   = 1'b0;
        end else begin
            if (bus_if.iomem_valid) begin
                valid_run++;
                check("iomem_addr", bus_if.iomem_addr, exp_addr);
                check("iomem_wdata", bus_if.iomem_wdata, exp_wdata);
                check("iomem_wstrb", 32'(bus_if.iomem_wstrb), 32'(exp_wstrb));
                check("cmd_ready_in_bus", 32'(bus_if.cmd_ready), 32'(0));
                check("valid_only_if_legal", 32'(bus_if.iomem_valid), 32'(!exp_illegal));
            end else if (prev_valid) begin
                last_len = valid_run;
                check("bus_len", 32'(valid_run), 32'(exp_len));
                valid_run = 0;
            end
            prev_valid = bus_if.iomem_valid;

            if (bus_if.rsp_valid) begin
                check("cmd_ready_in_rsp", 32'(bus_if.cmd_ready), 32'(0));
                check("valid_low_in_rsp", 32'(bus_if.iomem_valid), 32'(0));
                if (!prev_rsp) begin
                    check("rsp_rdata", bus_if.rsp_rdata, exp_rdata);
                    check("rsp_error", 32'(bus_if.rsp_error), 32'(exp_err));
                    rsp_seen++;
                    last_rdata = bus_if.rsp_rdata;
                    last_err   = bus_if.rsp_error;
                end else begin
                    check("rsp_rdata_hold", bus_if.rsp_rdata, prev_rdata);
                    check("rsp_error_hold", 32'(bus_if.rsp_error), 32'(prev_err));
                end
                prev_rdata = bus_if.rsp_rdata;
                prev_err   = bus_if.rsp_error;
            end
            prev_rsp = bus_if.rsp_valid;
        end
    end

    // ack_k: BUS cycle (1-based) in which the responder pulses ready; > T means never.
    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input int ack_k, input int stall,
                           input logic [31:0] rd);
        int guard;
        int n_before;
        exp_illegal = wr && (ws == 4'b0000);
        exp_addr    = a;
        exp_wdata   = wd;
        exp_wstrb   = wr ? ws : 4'b0000;
        exp_len     = (ack_k >= 1 && ack_k <= T) ? ack_k : T;
        if (exp_illegal || ack_k < 1 || ack_k > T) begin
            exp_err   = 1'b1;
            exp_rdata = ERR;
        end else begin
            exp_err   = 1'b0;
            exp_rdata = wr ? 32'h0 : rd;
        end
        n_before = rsp_seen;

        guard = 0;
        while (!bus_if.cmd_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("cmd_ready_wait", 32'(bus_if.cmd_ready), 32'(1));

        bus_if.cmd_write = wr;
        bus_if.cmd_addr  = a;
        bus_if.cmd_wdata = wd;
        bus_if.cmd_wstrb = ws;
        bus_if.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'b1;
        bus_if.cmd_wstrb = 4'b0000;
        bus_if.cmd_addr  = $urandom;
        bus_if.cmd_wdata = $urandom;

        if (exp_illegal) begin
            check("illegal_rsp_next", 32'(bus_if.rsp_valid), 32'(1));
            check("illegal_no_valid", 32'(bus_if.iomem_valid), 32'(0));
        end else begin
            check("valid_after_accept", 32'(bus_if.iomem_valid), 32'(1));
            for (int k = 1; k <= T; k++) begin
                bus_if.iomem_ready = (k == ack_k);
                bus_if.iomem_rdata = (k == ack_k) ? rd : $urandom;
                bus_if.cmd_valid   = 1'($urandom);
                @(posedge clk); #1;
                if (k == ack_k) break;
            end
            bus_if.iomem_ready = 1'b0;
            check("valid_drop", 32'(bus_if.iomem_valid), 32'(0));
            check("rsp_valid_rise", 32'(bus_if.rsp_valid), 32'(1));
        end

        for (int s = 0; s < stall; s++) begin
            bus_if.rsp_ready   = 1'b0;
            bus_if.iomem_ready = 1'($urandom);
            bus_if.iomem_rdata = $urandom;
            bus_if.cmd_valid   = 1'($urandom);
            @(posedge clk); #1;
        end
        bus_if.iomem_ready = 1'b0;
        bus_if.cmd_valid   = 1'b0;
        bus_if.rsp_ready   = 1'b1;
        @(posedge clk); #1;
        bus_if.rsp_ready = 1'b0;
        check("rsp_valid_after_hs", 32'(bus_if.rsp_valid), 32'(0));
        check("cmd_ready_after_hs", 32'(bus_if.cmd_ready), 32'(1));
        check("rsp_count", 32'(rsp_seen), 32'(n_before + 1));
        $display("txn wr=%0d addr=%h wstrb=%h ack_k=%0d stall=%0d -> rdata=%h err=%0d len=%0d",
                 wr, a, ws, ack_k, stall, last_rdata, last_err, last_len);
    endtask

    initial begin
        bus_if.cmd_valid   = 1'b0;
        bus_if.cmd_write   = 1'b0;
        bus_if.cmd_addr    = '0;
        bus_if.cmd_wdata   = '0;
        bus_if.cmd_wstrb   = '0;
        bus_if.rsp_ready   = 1'b0;
        bus_if.iomem_ready = 1'b0;
        bus_if.iomem_rdata = '0;
        exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_wstrb = '0;
        exp_err = 1'b0; exp_illegal = 1'b0; exp_len = 0;

        #23;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'(1));
        check("rst_iomem_valid", 32'(bus_if.iomem_valid), 32'(0));
        check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'(0));
        check("rst_rsp_rdata", bus_if.rsp_rdata, 32'h0);
        check("rst_rsp_error", 32'(bus_if.rsp_error), 32'(0));
        check("rst_iomem_addr", bus_if.iomem_addr, 32'h0);
        check("rst_iomem_wstrb", 32'(bus_if.iomem_wstrb), 32'(0));
        mon_en = 1'b1;

        // Write, responder acks two cycles after valid rises
        run_txn(1'b1, 32'h0300_0000, 32'h0000_A5A5, 4'b0011, 3, 0, 32'hDEAD_BEEF);
        check("lit_write_len", 32'(last_len), 32'(3));
        check("lit_write_rdata", last_rdata, 32'h0);
        check("lit_write_err", 32'(last_err), 32'(0));

        // Read with ready in the first BUS cycle
        run_txn(1'b0, 32'h0300_0000, 32'h0, 4'hF, 1, 0, 32'h1234_00A5);
        check("lit_read_len", 32'(last_len), 32'(1));
        check("lit_read_rdata", last_rdata, 32'h1234_00A5);

        // Timeout, then ready exactly in the expiry cycle
        run_txn(1'b0, 32'h0300_0004, 32'h0, 4'h0, 99, 0, 32'h0);
        check("lit_to_len", 32'(last_len), 32'(8));
        check("lit_to_rdata", last_rdata, 32'hFFFF_FFFF);
        check("lit_to_err", 32'(last_err), 32'(1));
        run_txn(1'b0, 32'h0300_0004, 32'h0, 4'h0, 8, 0, 32'hCAFE_0008);
        check("lit_to8_len", 32'(last_len), 32'(8));
        check("lit_to8_rdata", last_rdata, 32'hCAFE_0008);
        check("lit_to8_err", 32'(last_err), 32'(0));

        // Back-pressure followed by a second command
        run_txn(1'b1, 32'h0300_0008, 32'h5555_AAAA, 4'b1111, 1, 5, 32'h0);
        run_txn(1'b0, 32'h0300_0008, 32'h0, 4'h0, 2, 0, 32'h0BAD_F00D);

        // Illegal write with no byte enables
        run_txn(1'b1, 32'h0300_000C, 32'h1111_2222, 4'b0000, 1, 2, 32'h0);
        check("lit_illegal_rdata", last_rdata, 32'hFFFF_FFFF);
        check("lit_illegal_err", 32'(last_err), 32'(1));

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            logic [3:0] ws;
            ws = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            run_txn(1'($urandom), $urandom, $urandom, ws,
                    int'($urandom_range(1, 10)), int'($urandom_range(0, 3)), $urandom);
        end

        // Asynchronous reset while a read waits in BUS
        exp_illegal = 1'b0;
        exp_addr    = 32'h0300_0010;
        exp_wdata   = 32'h0000_0000;
        exp_wstrb   = 4'h0;
        exp_len     = T;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 32'h0300_0010;
        bus_if.cmd_wdata = 32'h0;
        bus_if.cmd_wstrb = 4'h0;
        bus_if.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
        check("rst_test_valid", 32'(bus_if.iomem_valid), 32'(1));
        @(posedge clk); #3;
        mon_en = 1'b0;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus_if.iomem_valid), 32'(0));
        check("async_rst_rsp", 32'(bus_if.rsp_valid), 32'(0));
        @(posedge clk); #3;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_cmd_ready", 32'(bus_if.cmd_ready), 32'(1));
        mon_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus_if.iomem_ready = 1'($urandom);
            @(posedge clk); #1;
            check("post_rst_no_rsp", 32'(bus_if.rsp_valid), 32'(0));
            check("post_rst_no_valid", 32'(bus_if.iomem_valid), 32'(0));
        end
        bus_if.iomem_ready = 1'b0;
        run_txn(1'b0, 32'h0300_0014, 32'h0, 4'h0, 2, 1, 32'h7777_0001);
        check("post_rst_read", last_rdata, 32'h7777_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
